// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and small decode helpers used by both the controller and the aligner.
package lsu_pkg;

  // funct3 encodings for access size and signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } lsu_state_e;

  // Access size in bytes; only meaningful for legal encodings.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] align_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational data alignment: builds the merged word for sub-word stores
// and the sign/zero-extended result for loads. The memory already returns
// the bytes starting at the access address in the low lanes, so no lane
// steering is needed here.
module load_store_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rd,
  input  logic [31:0] wd,
  output logic [31:0] merged,
  output logic [31:0] extended
);

  // Merge store bytes over the old word and extend load data by size/sign
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    merged   = wd;
    extended = rd;
    case (funct3[1:0])
      2'b00: begin
        merged   = {rd[31:8], wd[7:0]};
        extended = funct3[2] ? {24'b0, rd[7:0]} : {{24{rd[7]}}, rd[7:0]};
      end
      2'b01: begin
        merged   = {rd[31:16], wd[15:0]};
        extended = funct3[2] ? {16'b0, rd[15:0]} : {{16{rd[15]}}, rd[15:0]};
      end
      default: begin
        merged   = wd;
        extended = rd;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding request handshake in front of a
// word-wide data memory. Sub-word stores are done as read-modify-write,
// loads are extended, and out-of-range, misaligned or illegal accesses
// are answered with a fault without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter int MEM_BYTES        = 64,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       write_data,
  output logic              memWrite,
  input  logic [31:0]       read_data
);

  // One extra bit so addr+size never wraps back into range.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       write_data_q;
  logic [31:0]       rdata_q;
  logic              fault_q;

  logic              accept;
  logic [2:0]        req_size;
  logic [ADDR_W:0]   req_end;
  logic              range_err;
  logic              misaligned;
  logic              illegal;
  logic              req_fault;
  logic              req_is_sw;
  logic [31:0]       merged;
  logic [31:0]       extended;

  assign accept     = req_valid && (state_q == IDLE);
  assign req_size   = size_bytes(req_funct3);
  assign req_end    = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, req_size};
  assign range_err  = req_end > MEM_LIMIT;
  assign misaligned = !ALLOW_MISALIGNED && (|(req_addr[1:0] & align_mask(req_funct3)));
  assign illegal    = !funct3_legal(req_we, req_funct3);
  assign req_fault  = illegal || range_err || misaligned;
  assign req_is_sw  = req_we && (req_funct3 == F3_W);

  assign mem_addr   = addr_q;
  assign write_data = write_data_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_fault  = fault_q;

  load_store_align u_align (
    .funct3   (funct3_q),
    .rd       (read_data),
    .wd       (wdata_q),
    .merged   (merged),
    .extended (extended)
  );

  // State register; reset drops straight to IDLE so memWrite falls at once
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection and the state-decoded handshake/memory strobes
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    memWrite  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault)      state_d = RSP;
          else if (req_is_sw) state_d = WR;
          else                state_d = RD;
        end
      end
      RD:  state_d = we_q ? WR : RSP;
      WR: begin
        memWrite = 1'b1;
        state_d  = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches, store word and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      write_data_q <= '0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
    end else if (accept) begin
      addr_q   <= req_addr;
      we_q     <= req_we;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
      fault_q  <= req_fault;
      // Stores and faults answer with zero data.
      rdata_q  <= '0;
      // A full-word store goes straight to WR with the request data;
      // sub-word stores overwrite this with the merged word in RD.
      if (req_we) write_data_q <= req_wdata;
    end else if (state_q == RD) begin
      if (we_q) write_data_q <= merged;
      else      rdata_q      <= extended;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-array data memory model,
// a directed vector table, hand-written multi-cycle sequences and a
// randomized phase checked against a byte-level reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       write_data;
  logic              memWrite;
  logic [31:0]       read_data;

  load_store_unit #(
    .ADDR_W           (ADDR_W),
    .MEM_BYTES        (MEM_BYTES),
    .ALLOW_MISALIGNED (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .memWrite   (memWrite),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  // ---------------- data memory (environment) ----------------
  logic [7:0] mem [0:MEM_BYTES-1];
  logic       mem_load;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < MEM_BYTES; k++) mem[k] <= 8'(k);
    end else if (memWrite) begin
      for (int i = 0; i < 4; i++)
        if ({1'b0, mem_addr} + 33'(i) < 33'(MEM_BYTES))
          mem[mem_addr[5:0] + 6'(i)] <= write_data[8*i +: 8];
    end
  end

  always_comb begin
    read_data = '0;
    for (int i = 0; i < 4; i++)
      if ({1'b0, mem_addr} + 33'(i) < 33'(MEM_BYTES))
        read_data[8*i +: 8] = mem[mem_addr[5:0] + 6'(i)];
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic fault, output int lat, output int wr);
    int     size;
    longint end_a;
    logic   legal;
    logic [31:0] v;
    rdata = '0; fault = 1'b0; wr = 0; lat = 0; v = '0;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    legal = (size != 0) && !(we && f3[2]);
    end_a = longint'(addr) + longint'(size);
    if (!legal || end_a > longint'(MEM_BYTES)) begin
      fault = 1'b1;
      lat   = 1;
      return;
    end
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
      wr  = 1;
    end else begin
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
      if (!f3[2] && size < 4 && v[8*size-1])
        for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
      rdata = v;
      lat   = 2;
    end
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one request, measure accept-to-response edges and WR cycles, then handshake.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic fault, output int lat, output int wr);
    @(negedge clk);
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wr = 0;
    while (!rsp_valid && lat < 20) begin
      if (memWrite) wr++;
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    fault = rsp_fault;
    if (!rsp_valid) lat = 99;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          wr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic fault, input int lat, input int wr);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.fault = fault; v.lat = lat; v.wr = wr;
    vecs.push_back(v);
  endtask

  logic [31:0] got_rdata, exp_rdata, held;
  logic        got_fault, exp_fault;
  int          got_lat, exp_lat, got_wr, exp_wr;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata;

  initial begin
    reset = 1'b1; mem_load = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    for (int k = 0; k < MEM_BYTES; k++) ref_mem[k] = 8'(k);
    repeat (3) @(posedge clk);
    #1;
    check("reset.req_ready",  32'(req_ready), 32'd1);
    check("reset.rsp_valid",  32'(rsp_valid), 32'd0);
    check("reset.rsp_fault",  32'(rsp_fault), 32'd0);
    check("reset.rsp_rdata",  rsp_rdata,      32'd0);
    check("reset.memWrite",   32'(memWrite),  32'd0);
    check("reset.mem_addr",   mem_addr,       32'd0);
    check("reset.write_data", write_data,     32'd0);
    @(negedge clk);
    reset = 1'b0; mem_load = 1'b0;

    //      name        we    f3      addr          wdata          rdata        fault lat wr
    add_vec("lw_00",    1'b0, F3_W,   32'h00,       32'h0,         32'h03020100, 1'b0, 2, 0);
    add_vec("sb_04",    1'b1, F3_B,   32'h04,       32'h12345680,  32'h0,        1'b0, 3, 1);
    add_vec("lb_04",    1'b0, F3_B,   32'h04,       32'h0,         32'hFFFFFF80, 1'b0, 2, 0);
    add_vec("lbu_04",   1'b0, F3_BU,  32'h04,       32'h0,         32'h00000080, 1'b0, 2, 0);
    add_vec("lw_04",    1'b0, F3_W,   32'h04,       32'h0,         32'h07060580, 1'b0, 2, 0);
    add_vec("sh_08",    1'b1, F3_H,   32'h08,       32'h1234BEEF,  32'h0,        1'b0, 3, 1);
    add_vec("lh_08",    1'b0, F3_H,   32'h08,       32'h0,         32'hFFFFBEEF, 1'b0, 2, 0);
    add_vec("lw_08",    1'b0, F3_W,   32'h08,       32'h0,         32'h0B0ABEEF, 1'b0, 2, 0);
    add_vec("lb_3f",    1'b0, F3_B,   32'h3F,       32'h0,         32'h0000003F, 1'b0, 2, 0);
    add_vec("lw_3d",    1'b0, F3_W,   32'h3D,       32'h0,         32'h0,        1'b1, 1, 0);
    add_vec("ld_f3_011",1'b0, 3'b011, 32'h00,       32'h0,         32'h0,        1'b1, 1, 0);
    add_vec("ld_f3_110",1'b0, 3'b110, 32'h00,       32'h0,         32'h0,        1'b1, 1, 0);
    add_vec("ld_f3_111",1'b0, 3'b111, 32'h00,       32'h0,         32'h0,        1'b1, 1, 0);
    add_vec("st_f3_100",1'b1, F3_BU,  32'h00,       32'h55555555,  32'h0,        1'b1, 1, 0);
    add_vec("st_f3_011",1'b1, 3'b011, 32'h00,       32'h55555555,  32'h0,        1'b1, 1, 0);
    add_vec("sw_20",    1'b1, F3_W,   32'h20,       32'hDEADBEEF,  32'h0,        1'b0, 2, 1);
    add_vec("lw_20",    1'b0, F3_W,   32'h20,       32'h0,         32'hDEADBEEF, 1'b0, 2, 0);
    add_vec("lhu_22",   1'b0, F3_HU,  32'h22,       32'h0,         32'h0000DEAD, 1'b0, 2, 0);
    add_vec("lh_22",    1'b0, F3_H,   32'h22,       32'h0,         32'hFFFFDEAD, 1'b0, 2, 0);
    add_vec("lb_21",    1'b0, F3_B,   32'h21,       32'h0,         32'hFFFFFFBE, 1'b0, 2, 0);
    add_vec("lw_wrap",  1'b0, F3_W,   32'hFFFFFFFE, 32'h0,         32'h0,        1'b1, 1, 0);
    add_vec("lw_3c",    1'b0, F3_W,   32'h3C,       32'h0,         32'h3F3E3D3C, 1'b0, 2, 0);
    add_vec("lh_3f",    1'b0, F3_H,   32'h3F,       32'h0,         32'h0,        1'b1, 1, 0);
    add_vec("sw_3d",    1'b1, F3_W,   32'h3D,       32'h0,         32'h0,        1'b1, 1, 0);
    add_vec("sw_31",    1'b1, F3_W,   32'h31,       32'h11223344,  32'h0,        1'b0, 2, 1);
    add_vec("lw_30",    1'b0, F3_W,   32'h30,       32'h0,         32'h22334430, 1'b0, 2, 0);
    add_vec("lw_31",    1'b0, F3_W,   32'h31,       32'h0,         32'h11223344, 1'b0, 2, 0);
    add_vec("sh_3e",    1'b1, F3_H,   32'h3E,       32'h00005566,  32'h0,        1'b0, 3, 1);
    add_vec("lhu_3e",   1'b0, F3_HU,  32'h3E,       32'h0,         32'h00005566, 1'b0, 2, 0);
    add_vec("sb_3f",    1'b1, F3_B,   32'h3F,       32'hFFFFFFA5,  32'h0,        1'b0, 3, 1);
    add_vec("lb_3f_b",  1'b0, F3_B,   32'h3F,       32'h0,         32'hFFFFFFA5, 1'b0, 2, 0);

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, exp_rdata, exp_fault, exp_lat, exp_wr);
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, got_rdata, got_fault, got_lat, got_wr);
      check({vecs[i].name, ".rdata"}, got_rdata, vecs[i].rdata);
      check({vecs[i].name, ".fault"}, 32'(got_fault), 32'(vecs[i].fault));
      check({vecs[i].name, ".lat"},   32'(got_lat),   32'(vecs[i].lat));
      check({vecs[i].name, ".wr"},    32'(got_wr),    32'(vecs[i].wr));
    end

    // Response back-pressure: hold rsp_ready low while a second request waits.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h04; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("bp.rsp_valid_lat2", 32'(rsp_valid), 32'd1);
    held = rsp_rdata;
    check("bp.rdata", held, 32'h07060580);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h00; req_wdata = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp.rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp.rdata_stable",   rsp_rdata,       held);
      check("bp.req_ready_low",  32'(req_ready), 32'd0);
      check("bp.no_write",       32'(memWrite),  32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp.idle_after_hs", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      check("bp.no_second_rsp", 32'(rsp_valid), 32'd0);
    end
    run_req(1'b0, F3_W, 32'h00, 32'h0, got_rdata, got_fault, got_lat, got_wr);
    check("bp.sw_ignored", got_rdata, 32'h03020100);

    // Reset during the WR cycle of SB @0x10: the write must not happen.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h10; req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_wr.in_wr", 32'(memWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wr.memWrite_drop", 32'(memWrite),  32'd0);
    check("rst_wr.req_ready",     32'(req_ready), 32'd1);
    check("rst_wr.rsp_valid",     32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("rst_wr.memWrite_edge", 32'(memWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_wr.dropped", 32'(rsp_valid), 32'd0);
    end
    model(1'b0, F3_W, 32'h10, 32'h0, exp_rdata, exp_fault, exp_lat, exp_wr);
    run_req(1'b0, F3_W, 32'h10, 32'h0, got_rdata, got_fault, got_lat, got_wr);
    check("rst_wr.lw_10", got_rdata, 32'h13121110);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: r_f3 = F3_B;
          1: r_f3 = F3_H;
          2: r_f3 = F3_W;
          3: r_f3 = F3_BU;
          default: r_f3 = F3_HU;
        endcase
      end else begin
        r_f3 = 3'($urandom_range(0, 7));
      end
      r_addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES + 3));
      r_wdata = $urandom;
      model(r_we, r_f3, r_addr, r_wdata, exp_rdata, exp_fault, exp_lat, exp_wr);
      run_req(r_we, r_f3, r_addr, r_wdata, got_rdata, got_fault, got_lat, got_wr);
      check("rand.rdata", got_rdata,        exp_rdata);
      check("rand.fault", 32'(got_fault),   32'(exp_fault));
      check("rand.lat",   32'(got_lat),     32'(exp_lat));
      check("rand.wr",    32'(got_wr),      32'(exp_wr));
    end

    // Final sweep: every word of memory matches the model.
    for (int a = 0; a < MEM_BYTES; a += 4) begin
      model(1'b0, F3_W, 32'(a), 32'h0, exp_rdata, exp_fault, exp_lat, exp_wr);
      run_req(1'b0, F3_W, 32'(a), 32'h0, got_rdata, got_fault, got_lat, got_wr);
      check("sweep.rdata", got_rdata, exp_rdata);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
